// File: rtl/descrambler_frame_ctrl.sv
// ----------------------------------------------------------------------------
// descrambler_frame_ctrl
//
// Frame-sync controller that sits in front of the serial descrambler. It hunts
// for a fixed sync word in the received bit stream. At each frame boundary it
// pulses a reseed to the descrambler. It then forwards exactly one payload's
// worth of bits with the descrambler enable high, and checks the sync word that
// follows. A hit/miss flywheel decides when frame lock is declared and dropped.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        master enable; low forces HUNT and clears all counters
//   serial_in     received serial bit
//   serial_valid  serial_in carries a bit this cycle
//   desc_rst      one-cycle reseed pulse to the descrambler rst input
//   desc_enable   descrambler enable, high once per forwarded payload bit
//   desc_data     payload bit forwarded to the descrambler serial input
//   frame_start   one-cycle frame marker, coincident with desc_rst
//   locked        frame lock status
//   miss_cnt      consecutive sync misses seen while locked (saturates at 3)
//
// Every output is registered. Each output shows the effect of an accepted bit
// one cycle after that bit.
// ----------------------------------------------------------------------------
module descrambler_frame_ctrl #(
    parameter int                SYNC_W      = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD   = 16'hA5C3,
    parameter int                PAYLOAD_LEN = 64,
    parameter int                LOCK_HITS   = 3,
    parameter int                MISS_MAX    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       serial_in,
    input  logic       serial_valid,
    output logic       desc_rst,
    output logic       desc_enable,
    output logic       desc_data,
    output logic       frame_start,
    output logic       locked,
    output logic [1:0] miss_cnt
);

    localparam int BIT_CNT_W  = $clog2(PAYLOAD_LEN + 1);
    localparam int HIT_CNT_W  = $clog2(LOCK_HITS + 1);
    localparam int SYNC_CNT_W = $clog2(SYNC_W + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t                  state,    state_next;
    logic [SYNC_W-1:0]       sr,       sr_next;
    logic [BIT_CNT_W-1:0]    bit_cnt,  bit_cnt_next;
    logic [SYNC_CNT_W-1:0]   sync_cnt, sync_cnt_next;
    logic [HIT_CNT_W-1:0]    hit_cnt,  hit_cnt_next;
    logic [1:0]              miss_cnt_next;
    logic                    locked_next;

    logic                    desc_rst_next;
    logic                    desc_enable_next;
    logic                    desc_data_next;

    // Window that includes the bit being accepted this cycle. The match
    // decision is taken on it before sr itself is updated.
    logic [SYNC_W-1:0]       shifted;
    logic                    match;
    logic                    accept;
    logic                    last_payload_bit;
    logic                    last_sync_bit;
    logic [HIT_CNT_W-1:0]    hit_inc;
    logic [1:0]              miss_inc;

    assign shifted          = {sr[SYNC_W-2:0], serial_in};
    assign match            = (shifted == SYNC_WORD);
    assign accept           = enable && serial_valid;
    assign last_payload_bit = (bit_cnt == BIT_CNT_W'(PAYLOAD_LEN - 1));
    assign last_sync_bit    = (sync_cnt == SYNC_CNT_W'(SYNC_W - 1));

    // hit_cnt stops at LOCK_HITS. miss_cnt stops at 3, the largest value its
    // 2-bit output can show.
    assign hit_inc  = (int'(hit_cnt) >= LOCK_HITS) ? hit_cnt : hit_cnt + HIT_CNT_W'(1);
    assign miss_inc = (miss_cnt == 2'd3) ? 2'd3 : miss_cnt + 2'd1;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            sr          <= '0;
            bit_cnt     <= '0;
            sync_cnt    <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            locked      <= 1'b0;
            desc_rst    <= 1'b0;
            desc_enable <= 1'b0;
            desc_data   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_next;
            sr          <= sr_next;
            bit_cnt     <= bit_cnt_next;
            sync_cnt    <= sync_cnt_next;
            hit_cnt     <= hit_cnt_next;
            miss_cnt    <= miss_cnt_next;
            locked      <= locked_next;
            desc_rst    <= desc_rst_next;
            desc_enable <= desc_enable_next;
            desc_data   <= desc_data_next;
            frame_start <= desc_rst_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next    = state;
        sr_next       = sr;
        bit_cnt_next  = bit_cnt;
        sync_cnt_next = sync_cnt;
        hit_cnt_next  = hit_cnt;
        miss_cnt_next = miss_cnt;
        locked_next   = locked;

        if (!enable) begin
            state_next    = HUNT;
            sr_next       = '0;
            bit_cnt_next  = '0;
            sync_cnt_next = '0;
            hit_cnt_next  = '0;
            miss_cnt_next = '0;
            locked_next   = 1'b0;
        end else if (serial_valid) begin
            unique case (state)
                HUNT: begin
                    // sr stops shifting once a sync is found. A sync word
                    // that overlaps itself therefore resolves to the first
                    // match.
                    sr_next = shifted;
                    if (match) begin
                        state_next   = PAYLOAD;
                        bit_cnt_next = '0;
                        hit_cnt_next = HIT_CNT_W'(1);
                        if (LOCK_HITS == 1) begin
                            locked_next = 1'b1;
                        end
                    end
                end

                PAYLOAD: begin
                    if (last_payload_bit) begin
                        state_next    = CHECK;
                        bit_cnt_next  = '0;
                        sync_cnt_next = '0;
                        sr_next       = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                    end
                end

                CHECK: begin
                    sr_next = shifted;
                    if (last_sync_bit) begin
                        sync_cnt_next = '0;
                        if (match) begin
                            hit_cnt_next  = hit_inc;
                            miss_cnt_next = '0;
                            if (int'(hit_inc) >= LOCK_HITS) begin
                                locked_next = 1'b1;
                            end
                            state_next = PAYLOAD;
                        end else if (!locked) begin
                            hit_cnt_next = '0;
                            state_next   = HUNT;
                        end else if (int'(miss_inc) == MISS_MAX) begin
                            locked_next   = 1'b0;
                            hit_cnt_next  = '0;
                            miss_cnt_next = '0;
                            state_next    = HUNT;
                        end else begin
                            // Flywheel: keep framing on the expected
                            // boundary even though this sync was corrupted.
                            miss_cnt_next = miss_inc;
                            state_next    = PAYLOAD;
                        end
                    end else begin
                        sync_cnt_next = sync_cnt + SYNC_CNT_W'(1);
                    end
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode (registered in the state register process)
    // ------------------------------------------------------------------------
    always_comb begin
        desc_rst_next    = 1'b0;
        desc_enable_next = 1'b0;
        desc_data_next   = 1'b0;

        // A reseed marks every accepted transition into PAYLOAD. That covers
        // the first sync found in HUNT, a good sync in CHECK, and a flywheel
        // miss.
        if (accept && (state_next == PAYLOAD) && (state != PAYLOAD)) begin
            desc_rst_next = 1'b1;
        end

        if (accept && (state == PAYLOAD)) begin
            desc_enable_next = 1'b1;
            desc_data_next   = serial_in;
        end
    end

endmodule

// File: tb/tb_descrambler_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_descrambler_frame_ctrl
//
// Self-checking bench for descrambler_frame_ctrl. A behavioural model tracks
// the received stream bit by bit, using integer arithmetic on a sliding
// window. It predicts every registered output each cycle. Scenario tasks add
// their own frame-level checks on top.
// ----------------------------------------------------------------------------
module tb_descrambler_frame_ctrl;

    localparam int SYNC_W      = 16;
    localparam int SYNC_VAL    = 16'hA5C3;
    localparam int BAD_VAL     = 16'hA5C2;
    localparam int PAYLOAD_LEN = 64;
    localparam int LOCK_HITS   = 3;
    localparam int MISS_MAX    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       serial_in = 1'b0;
    logic       serial_valid = 1'b0;
    logic       desc_rst;
    logic       desc_enable;
    logic       desc_data;
    logic       frame_start;
    logic       locked;
    logic [1:0] miss_cnt;

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;
    int fs_cnt = 0;

    descrambler_frame_ctrl #(
        .SYNC_W      (SYNC_W),
        .SYNC_WORD   (16'hA5C3),
        .PAYLOAD_LEN (PAYLOAD_LEN),
        .LOCK_HITS   (LOCK_HITS),
        .MISS_MAX    (MISS_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .desc_rst     (desc_rst),
        .desc_enable  (desc_enable),
        .desc_data    (desc_data),
        .frame_start  (frame_start),
        .locked       (locked),
        .miss_cnt     (miss_cnt)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model. Its state is described in frame terms: looking for a
    // sync, counting payload bits, or collecting the next sync word.
    // ------------------------------------------------------------------------
    localparam int MODE_SEEK = 0;
    localparam int MODE_DATA = 1;
    localparam int MODE_SYNC = 2;

    int m_mode   = MODE_SEEK;
    int m_win    = 0;
    int m_count  = 0;
    int m_hits   = 0;
    int m_misses = 0;
    bit m_locked = 1'b0;
    bit m_rst    = 1'b0;
    bit m_en     = 1'b0;
    bit m_data   = 1'b0;
    bit model_ready = 1'b0;

    always @(posedge clk) begin
        m_rst = 1'b0;
        m_en  = 1'b0;
        m_data = 1'b0;
        if (rst || !enable) begin
            m_mode = MODE_SEEK;
            m_win = 0;
            m_count = 0;
            m_hits = 0;
            m_misses = 0;
            m_locked = 1'b0;
        end else if (serial_valid) begin
            m_win = ((m_win << 1) | int'(serial_in)) & 16'hFFFF;
            if (m_mode == MODE_SEEK) begin
                if (m_win == SYNC_VAL) begin
                    m_mode = MODE_DATA;
                    m_count = 0;
                    m_hits = 1;
                    m_locked = (LOCK_HITS == 1);
                    m_rst = 1'b1;
                end
            end else if (m_mode == MODE_DATA) begin
                m_en = 1'b1;
                m_data = serial_in;
                m_count++;
                if (m_count == PAYLOAD_LEN) begin
                    m_mode = MODE_SYNC;
                    m_count = 0;
                    m_win = 0;
                end
            end else begin
                m_count++;
                if (m_count == SYNC_W) begin
                    m_count = 0;
                    if (m_win == SYNC_VAL) begin
                        m_hits = (m_hits + 1 > LOCK_HITS) ? LOCK_HITS : m_hits + 1;
                        if (m_hits == LOCK_HITS) m_locked = 1'b1;
                        m_misses = 0;
                        m_rst = 1'b1;
                        m_mode = MODE_DATA;
                    end else if (!m_locked) begin
                        m_hits = 0;
                        m_mode = MODE_SEEK;
                    end else begin
                        m_misses = (m_misses == 3) ? 3 : m_misses + 1;
                        if (m_misses == MISS_MAX) begin
                            m_locked = 1'b0;
                            m_hits = 0;
                            m_misses = 0;
                            m_mode = MODE_SEEK;
                        end else begin
                            m_rst = 1'b1;
                            m_mode = MODE_DATA;
                        end
                    end
                end
            end
        end
        model_ready = 1'b1;
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            vectors++;
            if ({desc_rst, desc_enable, desc_data, frame_start, locked, miss_cnt}
                !== {m_rst, m_en, m_data, m_rst, m_locked, 2'(m_misses)}) begin
                miscompares++;
                $display("[TB] FAIL model_cycle t=%0t got rst=%b en=%b data=%b fs=%b lock=%b miss=%0d expected rst=%b en=%b data=%b fs=%b lock=%b miss=%0d",
                         $time, desc_rst, desc_enable, desc_data, frame_start, locked, miss_cnt,
                         m_rst, m_en, m_data, m_rst, m_locked, m_misses);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus primitives
    // ------------------------------------------------------------------------
    task automatic step(input logic v, input logic b);
        serial_valid = v;
        serial_in = b;
        @(negedge clk);
        if (desc_enable) en_cnt++;
        if (frame_start) fs_cnt++;
    endtask

    task automatic send_bit(input logic b, input bit gapped);
        if (gapped && $urandom_range(0, 1) == 1) step(1'b0, 1'($urandom));
        step(1'b1, b);
    endtask

    task automatic send_word(input logic [15:0] w, input bit gapped);
        for (int i = 15; i >= 0; i--) send_bit(w[i], gapped);
    endtask

    task automatic send_payload(input int n, input bit gapped);
        for (int i = 0; i < n; i++) send_bit(1'($urandom), gapped);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b1;
        step(1'b1, 1'($urandom));
        rst = 1'b0;
    endtask

    // Noise straight after reset cannot complete a sync word, because the
    // cleared window still holds leading zeros.
    task automatic acquire(input bit gapped);
        do_reset();
        send_payload(10, gapped);
        for (int f = 0; f < 3; f++) begin
            send_word(16'hA5C3, gapped);
            send_payload(PAYLOAD_LEN, gapped);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        send_word(16'hA5C3, 1'b0);
        send_payload(5, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'(i));
            vectors++;
            if ({desc_rst, desc_enable, desc_data, frame_start, locked, miss_cnt} !== 7'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cycle %0d got %b expected 0000000", i,
                         {desc_rst, desc_enable, desc_data, frame_start, locked, miss_cnt});
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_acquisition();
        do_reset();
        send_payload(10, 1'b0);
        for (int f = 0; f < 3; f++) begin
            send_word(16'hA5C3, 1'b0);
            vectors++;
            if (frame_start !== 1'b1 || desc_rst !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL acq_frame_start frame %0d got fs=%b rst=%b expected 1", f, frame_start, desc_rst);
            end
            vectors++;
            if (locked !== (f == 2)) begin
                miscompares++;
                $display("[TB] FAIL acq_locked frame %0d got %b expected %b", f, locked, (f == 2));
            end
            en_cnt = 0;
            send_payload(PAYLOAD_LEN, 1'b0);
            vectors++;
            if (en_cnt != PAYLOAD_LEN) begin
                miscompares++;
                $display("[TB] FAIL acq_enable_count frame %0d got %0d expected %0d", f, en_cnt, PAYLOAD_LEN);
            end
        end
    endtask

    task automatic test_false_start();
        do_reset();
        send_payload(10, 1'b0);
        send_word(16'hA5C3, 1'b0);
        send_payload(PAYLOAD_LEN, 1'b0);
        send_word(16'hA5C2, 1'b0);
        vectors++;
        if (frame_start !== 1'b0 || locked !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL false_start_decision got fs=%b lock=%b expected 0 0", frame_start, locked);
        end
        en_cnt = 0;
        send_zeros(20);
        vectors++;
        if (en_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL false_start_hunt_enables got %0d expected 0", en_cnt);
        end
        send_word(16'hA5C3, 1'b0);
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL false_start_reacquire got fs=%b expected 1", frame_start);
        end
        en_cnt = 0;
        send_payload(PAYLOAD_LEN, 1'b0);
        vectors++;
        if (en_cnt != PAYLOAD_LEN) begin
            miscompares++;
            $display("[TB] FAIL false_start_payload got %0d expected %0d", en_cnt, PAYLOAD_LEN);
        end
    endtask

    task automatic test_flywheel();
        acquire(1'b0);
        send_word(16'hA5C2, 1'b0);
        vectors++;
        if (miss_cnt !== 2'd1 || frame_start !== 1'b1 || locked !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flywheel_miss got miss=%0d fs=%b lock=%b expected 1 1 1", miss_cnt, frame_start, locked);
        end
        en_cnt = 0;
        send_payload(PAYLOAD_LEN, 1'b0);
        vectors++;
        if (en_cnt != PAYLOAD_LEN) begin
            miscompares++;
            $display("[TB] FAIL flywheel_payload got %0d expected %0d", en_cnt, PAYLOAD_LEN);
        end
        send_word(16'hA5C3, 1'b0);
        vectors++;
        if (miss_cnt !== 2'd0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL flywheel_recover got miss=%0d fs=%b expected 0 1", miss_cnt, frame_start);
        end
    endtask

    task automatic test_loss_of_lock();
        acquire(1'b0);
        send_word(16'hA5C2, 1'b0);
        send_payload(PAYLOAD_LEN, 1'b0);
        send_word(16'hA5C2, 1'b0);
        vectors++;
        if (locked !== 1'b0 || desc_rst !== 1'b0 || frame_start !== 1'b0 || miss_cnt !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL loss_of_lock got lock=%b rst=%b fs=%b miss=%0d expected 0 0 0 0",
                     locked, desc_rst, frame_start, miss_cnt);
        end
        en_cnt = 0;
        send_zeros(40);
        vectors++;
        if (en_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL loss_hunt_enables got %0d expected 0", en_cnt);
        end
    endtask

    task automatic test_gapped_and_abort();
        do_reset();
        send_payload(10, 1'b1);
        for (int f = 0; f < 3; f++) begin
            send_word(16'hA5C3, 1'b1);
            en_cnt = 0;
            send_payload(PAYLOAD_LEN, 1'b1);
            vectors++;
            if (en_cnt != PAYLOAD_LEN) begin
                miscompares++;
                $display("[TB] FAIL gapped_enable_count frame %0d got %0d expected %0d", f, en_cnt, PAYLOAD_LEN);
            end
        end
        vectors++;
        if (locked !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL gapped_locked got %b expected 1", locked);
        end
        send_word(16'hA5C3, 1'b1);
        send_payload(20, 1'b1);
        enable = 1'b0;
        step(1'b1, 1'b1);
        vectors++;
        if (desc_enable !== 1'b0 || locked !== 1'b0 || frame_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs got en=%b lock=%b fs=%b expected 0 0 0", desc_enable, locked, frame_start);
        end
        enable = 1'b1;
        en_cnt = 0;
        send_zeros(30);
        vectors++;
        if (en_cnt != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_hunt_enables got %0d expected 0", en_cnt);
        end
    endtask

    // Random framed stream with corrupted syncs, slips, gaps, and occasional
    // enable drops or resets. Only the model comparison checks this scenario.
    task automatic test_random();
        bit q[$];
        logic [15:0] w;
        logic b;
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (q.size() == 0) begin
                if ($urandom_range(0, 7) == 0) q.push_back(1'($urandom));
                w = 16'hA5C3;
                if ($urandom_range(0, 3) == 0) w[$urandom_range(0, 15)] ^= 1'b1;
                for (int i = 15; i >= 0; i--) q.push_back(w[i]);
                for (int i = 0; i < PAYLOAD_LEN; i++) q.push_back(1'($urandom));
            end
            enable = ($urandom_range(0, 399) != 0);
            rst = ($urandom_range(0, 999) == 0);
            b = 1'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                b = q.pop_front();
                step(1'b1, b);
            end else begin
                step(1'b0, b);
            end
        end
        rst = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_acquisition();
        test_false_start();
        test_flywheel();
        test_loss_of_lock();
        test_gapped_and_abort();
        test_random();
        step(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/descrambler_frame_ctrl.md
# descrambler_frame_ctrl

Frame-sync controller that sequences the serial descrambler. Hunts for a fixed sync word in the incoming serial stream, reseeds the descrambler at each frame boundary, gates its enable for exactly one payload of bits, then checks the next sync word. A hit/miss flywheel declares and drops lock. Sits between the serial receive front end and the descrambler's rst/enable/de_serial_in inputs.

## Interface
- SYNC_W, 16, sync word width in bits
- SYNC_WORD, 16'hA5C3, sync pattern; first received bit is the MSB
- PAYLOAD_LEN, 64, payload bits per frame (≥1)
- LOCK_HITS, 3, consecutive sync hits needed to assert locked (≥1)
- MISS_MAX, 2, consecutive misses while locked that drop lock (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  master enable; low forces HUNT and clears counters
- serial_in  in  1  received serial bit
- serial_valid  in  1  serial_in valid this cycle
- desc_rst  out  1  one-cycle reseed pulse to descrambler rst
- desc_enable  out  1  descrambler enable, high for each payload bit
- desc_data  out  1  payload bit to descrambler de_serial_in
- frame_start  out  1  one-cycle pulse, same cycle as desc_rst
- locked  out  1  frame lock status
- miss_cnt  out  2  current consecutive-miss count (saturates at 3)

## Operation
- Sync shift register sr[SYNC_W-1:0] shifts serial_in in at LSB on each valid bit in HUNT. match = {sr[SYNC_W-2:0], serial_in} == SYNC_WORD, evaluated on the accepted bit.
- States: HUNT, PAYLOAD, CHECK.
- HUNT: on a valid bit with match -> PAYLOAD; pulse desc_rst/frame_start; hit_cnt=1; locked=1 if LOCK_HITS==1.
- PAYLOAD: each valid bit drives desc_enable=1, desc_data=serial_in; bit_cnt increments. On the PAYLOAD_LEN-th bit -> CHECK, bit_cnt=0, sr cleared.
- CHECK: shift SYNC_W valid bits into sr. On the SYNC_W-th bit compare:
  - Hit: hit_cnt++ (saturating at LOCK_HITS); locked=1 when hit_cnt reaches LOCK_HITS; miss_cnt=0; pulse desc_rst/frame_start; -> PAYLOAD.
  - Miss, not locked: hit_cnt=0 -> HUNT.
  - Miss, locked: miss_cnt++. If new miss_cnt == MISS_MAX: locked=0, hit_cnt=0, miss_cnt=0 -> HUNT. Otherwise flywheel: pulse desc_rst/frame_start -> PAYLOAD.
- Invalid cycles (serial_valid=0): no state/counter change; desc_enable=0.
- enable=0: state HUNT, sr/hit_cnt/miss_cnt/bit_cnt cleared, locked=0, all pulse outputs 0; overrides serial_valid.
- Counter widths: bit_cnt $clog2(PAYLOAD_LEN+1), hit_cnt $clog2(LOCK_HITS+1), sync bit count $clog2(SYNC_W+1).

## Timing
- All outputs registered; one-cycle latency from accepted bit to desc_enable/desc_data/desc_rst/frame_start.
- desc_rst asserts the cycle after the final sync bit. The earliest desc_enable is the following cycle, so reseed always precedes the first payload bit by ≥1 cycle.
- desc_enable is never high in HUNT or CHECK. Exactly PAYLOAD_LEN desc_enable pulses per frame.
- locked and miss_cnt update in the same cycle as the frame_start pulse, or the HUNT transition, that results from the decision.
- Reset values: desc_rst=0, desc_enable=0, desc_data=0, frame_start=0, locked=0, miss_cnt=0; state HUNT, sr=0.
- Reset or enable drop mid-PAYLOAD aborts the frame immediately. No further desc_enable pulses; the next cycle shows reset values.
- Sync word overlapping itself in HUNT: the first match wins; the shift continues only in CHECK.

## Test plan
- Reset: rst=1 for 2 cycles with toggling input -> all outputs 0, no desc_enable.
- Acquisition: noise, then 16'hA5C3, then 64 bits, repeated 3 frames.
  - frame_start one cycle after each sync's last bit.
  - 64 desc_enable pulses per frame.
  - locked=1 after the third sync.
- False start: sync, 64 bits, then a corrupted sync (16'hA5C2) while unlocked -> HUNT, no desc_enable until the next valid sync.
- Flywheel: locked, one corrupted sync -> miss_cnt=1, frame_start still pulses, payload continues. The next good sync -> miss_cnt=0.
- Loss of lock: locked, two consecutive corrupted syncs -> locked=0 and HUNT after the second; no desc_rst on the second miss.
- Gapped valid and abort: serial_valid at 50% duty -> exactly 64 enables per frame. Dropping enable at payload bit 20 -> desc_enable low the next cycle, locked=0, HUNT.
